cond_unit: RTL
==============

// Module: cond_unit
// PURPOSE
//  Consumer end of the ALU flag interface. Holds the architectural NZCV status register,
//  which is written from ALU flags. Evaluates each instruction's 4-bit condition field
//  against the stored flags. Gates the write enables (PC, register file, memory) of
//  conditionally executed instructions. Returns the stored carry to the ALU ci input.
//  Sits between the control decoder and the datapath of the single-cycle processor.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset, ordered {N,Z,C,V}
//  CNT_W        16       width of the performance counters (used only with COND_PERF_CNT_EN)
// PORTS
//  clk          in   1      system clock; all state updates on the rising edge
//  reset        in   1      synchronous, active-high reset
//  cond         in   4      instruction condition field
//  alu_flags    in   4      {f_N,f_Z,f_C,f_V} from the ALU for the current instruction
//  flag_w       in   2      [1]: write N,Z; [0]: write C,V (from the decoder)
//  pc_s         in   1      decoder PC-write request
//  reg_w        in   1      decoder register-write request
//  mem_w        in   1      decoder memory-write request
//  no_write     in   1      compare-class op: suppress the register write
//  carry_use    in   1      op consumes carry (ADC/SBC): drive ci from the stored C
//  cond_ex      out  1      condition passed for the current instruction
//  pc_src       out  1      pc_s & cond_ex
//  reg_write    out  1      reg_w & cond_ex & ~no_write
//  mem_write    out  1      mem_w & cond_ex
//  flags        out  4      stored NZCV register
//  ci           out  1      carry_use ? flags[C] : 1'b0
//  exec_cnt     out  CNT_W  (COND_PERF_CNT_EN only) number of executed instructions
//  squash_cnt   out  CNT_W  (COND_PERF_CNT_EN only) number of squashed instructions
// BEHAVIOUR
//  - cond_ex is combinational from cond and the registered flags (not alu_flags).
//  - Condition table:
//    - EQ 0000: Z;    NE 0001: !Z;   CS 0010: C;    CC 0011: !C
//    - MI 0100: N;    PL 0101: !N;   VS 0110: V;    VC 0111: !V
//    - HI 1000: C&!Z; LS 1001: !C|Z
//    - GE 1010: N==V; LT 1011: N!=V; GT 1100: !Z&(N==V); LE 1101: Z|(N!=V)
//    - AL 1110: 1;    1111: 1 (treated as AL)
//  - Rising edge, reset=0:
//    - N,Z <= alu_flags[3:2] iff flag_w[1] & cond_ex.
//    - C,V <= alu_flags[1:0] iff flag_w[0] & cond_ex.
//    - Otherwise hold. Flag writes are never partial within a pair.
//  - Latency: a flag write is visible to cond_ex/ci on the next cycle. There is no bypass.
//  - Reset:
//    - flags <= RESET_FLAGS; counters <= 0.
//    - While reset=1, pc_src, reg_write and mem_write are forced to 0.
//    - Reset wins over a simultaneous flag_w.
//  - A squashed instruction (cond_ex=0) asserts no write enable and changes no flags.
//  - ci is purely combinational; with carry_use=0 it is exactly 0.
// CONFIGURATION
//  COND_PERF_CNT_EN defined:
//    - Every non-reset cycle increments exec_cnt if cond_ex, else squash_cnt.
//    - Both counters saturate at all-ones (no wrap-around).
//  COND_PERF_CNT_EN undefined:
//    - The counter ports and their logic are absent.
//    - The rest of the behaviour is identical.
// STRUCTURE
//  - Package cond_pkg holds:
//    - enum cond_e (EQ..AL, 4-bit), the encodings in the condition table above.
//    - Localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
//    - typedef nzcv_t = logic [3:0].
//  - Sub-module cond_check: combinational (cond, flags) -> cond_ex.
//  - cond_unit contains the flag register, the gating and the counters.
// TESTING
//  1. Reset with RESET_FLAGS=0 -> flags=0000; cond=EQ gives cond_ex=0; cond=AL with
//     reg_w=1 gives reg_write=1.
//  2. cond=AL, flag_w=11, alu_flags=0100 -> next cycle flags=0100. Then cond=EQ, mem_w=1
//     -> mem_write=1; cond=NE -> mem_write=0.
//  3. flags=0100, cond=NE, flag_w=11, alu_flags=1010 -> squashed: flags stay 0100,
//     all write enables 0.
//  4. flag_w=10 only, alu_flags=1111 from flags=0000 -> flags=1100 (C,V untouched).
//     Then cond=LT -> cond_ex=1; cond=GE -> cond_ex=0.
//  5. flags=0010, carry_use=1 -> ci=1; carry_use=0 -> ci=0. Reset asserted together with
//     flag_w=11 -> flags=RESET_FLAGS, pc_src=0.
//  6. COND_PERF_CNT_EN with CNT_W=2: 5 AL cycles -> exec_cnt=3 (saturated),
//     squash_cnt=0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the condition unit: condition-field encodings and NZCV bit positions.
package cond_pkg;

    typedef logic [3:0] nzcv_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's condition
// field passes against the stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  nzcv_t      flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        // 4'b1111 falls through to the default and behaves as AL
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// NZCV status register, condition gating of write enables and carry return to the ALU.
// Optional execute/squash counters are built only when COND_PERF_CNT_EN is defined.
module cond_unit
    import cond_pkg::*;
#(
    parameter nzcv_t RESET_FLAGS = 4'b0000
`ifdef COND_PERF_CNT_EN
    ,
    parameter int    CNT_W       = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pc_s,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       carry_use,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags,
    output logic       ci
`ifdef COND_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    logic gate;

    cond_check u_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign gate      = cond_ex & ~reset;
    assign pc_src    = pc_s & gate;
    assign reg_write = reg_w & gate & ~no_write;
    assign mem_write = mem_w & gate;
    assign ci        = carry_use & flags[FLAG_C];

    // Flags update in pairs only; a squashed instruction leaves them untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= RESET_FLAGS;
        end else begin
            if (flag_w[1] && cond_ex) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[0] && cond_ex) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

`ifdef COND_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (cond_ex) begin
            if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
        end else begin
            if (squash_cnt != '1) squash_cnt <= squash_cnt + 1'b1;
        end
    end
`endif

endmodule
